// File: rtl/pc_control.sv
// -----------------------------------------------------------------------------
// pc_control
//   Program-counter and fetch-sequencing stage placed directly upstream of the
//   instruction ROM. The ROM has a synchronous read with one cycle of latency,
//   so every instruction takes a FETCH cycle (address presented) followed by an
//   EXEC cycle (ROM data valid). The next PC is either the sequential increment
//   or a resolved branch target. Stall, halt and out-of-range fault are handled
//   here.
//
// Ports
//   clk            in   rising-edge system clock
//   reset          in   asynchronous, active-high reset
//   stall          in   datapath not ready; hold the current instruction in EXEC
//   branch_taken   in   resolved branch/jump in this EXEC cycle
//   branch_target  in   [31:0] absolute next PC when branch_taken=1
//   halt_req       in   halt instruction decoded in this EXEC cycle
//   PC             out  [31:0] current PC, fetch address
//   PC_next_seq    out  [31:0] PC + PC_STEP, for link-register writes
//   instr_valid    out  ROM output valid this cycle (EXEC)
//   halted         out  core halted, sticky until reset
//   pc_fault       out  halt caused by an out-of-range next PC, sticky
//   retired_count  out  [31:0] committed PC updates (only with the macro)
//
// Configuration
//   PC_CONTROL_RETIRE_CNT_EN : when defined, adds the retired_count output and
//   its counter. Undefined by default.
// -----------------------------------------------------------------------------
module pc_control #(
    parameter logic [31:0] RESET_PC   = 32'd0,
    parameter logic [31:0] PC_STEP    = 32'd1,
    parameter int unsigned IMEM_DEPTH = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        halt_req,
    output logic [31:0] PC,
    output logic [31:0] PC_next_seq,
    output logic        instr_valid,
    output logic        halted,
    output logic        pc_fault
`ifdef PC_CONTROL_RETIRE_CNT_EN
    ,
    output logic [31:0] retired_count
`endif
);

    localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_DEPTH);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        instr_valid_q, instr_valid_d;
    logic        halted_q, halted_d;
    logic        pc_fault_q, pc_fault_d;

    logic [31:0] pc_seq_s;
    logic [31:0] pc_cand_s;
    logic        out_of_range_s;
    logic        fault_s;

    // Sequential increment wraps modulo 2^32 before the range check.
    assign pc_seq_s       = pc_q + PC_STEP;
    assign pc_cand_s      = branch_taken ? branch_target : pc_seq_s;
    assign out_of_range_s = (pc_cand_s >= IMEM_LIMIT);

    // State, PC and registered status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_FETCH;
            pc_q          <= RESET_PC;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
            pc_fault_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_valid_q <= instr_valid_d;
            halted_q      <= halted_d;
            pc_fault_q    <= pc_fault_d;
        end
    end

    // Next-state and next-PC selection; in EXEC halt_req beats stall beats update.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        fault_s = 1'b0;
        case (state_q)
            ST_FETCH: begin
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (halt_req) begin
                    state_d = ST_HALT;
                end else if (stall) begin
                    state_d = ST_EXEC;
                end else if (out_of_range_s) begin
                    // PC stays on the faulting instruction.
                    state_d = ST_HALT;
                    fault_s = 1'b1;
                end else begin
                    state_d = ST_FETCH;
                    pc_d    = pc_cand_s;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                // Corrupted encoding: park safely in HALT.
                state_d = ST_HALT;
            end
        endcase
    end

    // Registered outputs are derived from the upcoming state so they line up with it.
    always_comb begin
        instr_valid_d = (state_d == ST_EXEC);
        halted_d      = halted_q | (state_d == ST_HALT);
        pc_fault_d    = pc_fault_q | fault_s;
    end

    assign PC          = pc_q;
    assign PC_next_seq = pc_seq_s;
    assign instr_valid = instr_valid_q;
    assign halted      = halted_q;
    assign pc_fault    = pc_fault_q;

`ifdef PC_CONTROL_RETIRE_CNT_EN
    logic [31:0] retired_q, retired_d;
    logic        commit_s;

    // A commit is exactly the EXEC -> FETCH transition.
    assign commit_s = (state_q == ST_EXEC) && (state_d == ST_FETCH);

    // Retire counter increment, wrapping modulo 2^32.
    always_comb begin
        retired_d = retired_q + (commit_s ? 32'd1 : 32'd0);
    end

    // Retire counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retired_q <= 32'd0;
        end else begin
            retired_q <= retired_d;
        end
    end

    assign retired_count = retired_q;
`endif

endmodule

// File: tb/tb_pc_control.sv
module tb_pc_control;

    localparam int unsigned DEPTH = 1024;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'd0;
    logic        halt_req = 1'b0;
    logic [31:0] PC;
    logic [31:0] PC_next_seq;
    logic        instr_valid;
    logic        halted;
    logic        pc_fault;
`ifdef PC_CONTROL_RETIRE_CNT_EN
    logic [31:0] retired_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Instruction-level reference: PC, whether the ROM data is being consumed,
    // stopped flag, fault flag, retired instructions.
    logic [31:0] m_pc;
    bit          m_in_exec;
    bit          m_stopped;
    bit          m_fault;
    logic [31:0] m_retired;

    pc_control #(
        .RESET_PC  (32'd0),
        .PC_STEP   (32'd1),
        .IMEM_DEPTH(DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .halt_req     (halt_req),
        .PC           (PC),
        .PC_next_seq  (PC_next_seq),
        .instr_valid  (instr_valid),
        .halted       (halted),
        .pc_fault     (pc_fault)
`ifdef PC_CONTROL_RETIRE_CNT_EN
        ,
        .retired_count(retired_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"}, PC, m_pc);
        check({tag, ".seq"}, PC_next_seq, m_pc + 32'd1);
        check({tag, ".valid"}, {31'd0, instr_valid}, {31'd0, m_in_exec});
        check({tag, ".halted"}, {31'd0, halted}, {31'd0, m_stopped});
        check({tag, ".fault"}, {31'd0, pc_fault}, {31'd0, m_fault});
`ifdef PC_CONTROL_RETIRE_CNT_EN
        check({tag, ".retired"}, retired_count, m_retired);
`endif
    endtask

    function automatic void model_reset();
        m_pc      = 32'd0;
        m_in_exec = 1'b0;
        m_stopped = 1'b0;
        m_fault   = 1'b0;
        m_retired = 32'd0;
    endfunction

    // One clock edge of the instruction-level rules.
    function automatic void model_edge(input bit s, input bit b, input logic [31:0] t, input bit h);
        logic [31:0] nxt;
        if (m_stopped) return;
        if (!m_in_exec) begin
            m_in_exec = 1'b1;
            return;
        end
        if (h) begin
            m_stopped = 1'b1;
            m_in_exec = 1'b0;
            return;
        end
        if (s) return;
        nxt = b ? t : m_pc + 32'd1;
        if (nxt >= DEPTH) begin
            m_stopped = 1'b1;
            m_fault   = 1'b1;
            m_in_exec = 1'b0;
        end else begin
            m_pc      = nxt;
            m_in_exec = 1'b0;
            m_retired = m_retired + 32'd1;
        end
    endfunction

    // Drive inputs at a falling edge, advance one rising edge, check at the next falling edge.
    task automatic cycle(input bit s, input bit b, input logic [31:0] t, input bit h, input string tag);
        stall = s; branch_taken = b; branch_target = t; halt_req = h;
        @(posedge clk);
        model_edge(s, b, t, h);
        @(negedge clk);
        check_all(tag);
    endtask

    // Reset pulse asserted between edges (entered and left at a falling edge).
    task automatic apply_reset();
        #2 reset = 1'b1;
        #1 model_reset();
        check_all("reset");
        @(negedge clk);
        reset = 1'b0;
        check_all("post_reset");
    endtask

    // Free-run sequentially until the model is in EXEC at the wanted PC.
    task automatic run_to_exec(input logic [31:0] target);
        int budget = 4000;
        while (!(m_in_exec && m_pc == target) && budget > 0) begin
            cycle(1'b0, 1'b0, 32'd0, 1'b0, "run");
            budget--;
        end
        check("run_to_budget", {31'd0, (budget > 0)}, 32'd1);
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        apply_reset();

        // Free run: PC 0,0,1,1,2,2 with instr_valid 0,1,0,1.
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 32'd0, 1'b0, "free");
        check("free_pc_after8", PC, 32'd4);

        // Branch from EXEC at PC=5 to 40.
        run_to_exec(32'd5);
        check("br_seq_at5", PC_next_seq, 32'd6);
        cycle(1'b0, 1'b1, 32'd40, 1'b0, "br");
        check("br_pc40", PC, 32'd40);
        check("br_fetch", {31'd0, instr_valid}, 32'd0);

        // Stall at PC=3 with concurrent branch, then branch on first free edge.
        cycle(1'b0, 1'b0, 32'd0, 1'b0, "to_exec40");
        cycle(1'b0, 1'b1, 32'd3, 1'b0, "br3");
        cycle(1'b0, 1'b0, 32'd0, 1'b0, "exec3");
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b1, 32'd100, 1'b0, "stall");
            check("stall_pc", PC, 32'd3);
            check("stall_valid", {31'd0, instr_valid}, 32'd1);
        end
        cycle(1'b0, 1'b1, 32'd100, 1'b0, "stall_rel");
        check("stall_br_pc", PC, 32'd100);

        // halt_req beats stall and branch.
        apply_reset();
        run_to_exec(32'd7);
        cycle(1'b1, 1'b1, 32'd50, 1'b1, "halt");
        check("halt_pc", PC, 32'd7);
        check("halt_flag", {31'd0, halted}, 32'd1);
        check("halt_nofault", {31'd0, pc_fault}, 32'd0);

        // Sequential fault at PC=1023, then frozen for 10 cycles of random input.
        apply_reset();
        cycle(1'b0, 1'b0, 32'd0, 1'b0, "exec0");
        cycle(1'b0, 1'b1, 32'd1023, 1'b0, "br1023");
        cycle(1'b0, 1'b0, 32'd0, 1'b0, "exec1023");
        cycle(1'b0, 1'b0, 32'd0, 1'b0, "fault_seq");
        check("fseq_pc", PC, 32'd1023);
        check("fseq_fault", {31'd0, pc_fault}, 32'd1);
        for (int i = 0; i < 10; i++)
            cycle(1'($urandom), 1'($urandom), $urandom, 1'($urandom), "frozen");
        check("frozen_pc", PC, 32'd1023);
        check("frozen_valid", {31'd0, instr_valid}, 32'd0);

        // Branch-target fault.
        apply_reset();
        cycle(1'b0, 1'b0, 32'd0, 1'b0, "exec0b");
        cycle(1'b0, 1'b1, 32'd2000, 1'b0, "fault_br");
        check("fbr_pc", PC, 32'd0);
        check("fbr_fault", {31'd0, pc_fault}, 32'd1);

        // Randomized run with occasional re-reset once stopped.
        apply_reset();
        for (int i = 0; i < 600; i++) begin
            logic [31:0] tgt;
            tgt = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 1100));
            cycle($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, tgt,
                  $urandom_range(0, 63) == 0, "rand");
            if (m_stopped && $urandom_range(0, 3) == 0) apply_reset();
        end

        // Asynchronous reset mid-EXEC at PC=12.
        apply_reset();
        run_to_exec(32'd12);
        check("pre_rst_pc", PC, 32'd12);
`ifdef PC_CONTROL_RETIRE_CNT_EN
        check("pre_rst_retired", retired_count, 32'd12);
`endif
        #2 reset = 1'b1;
        #1 model_reset();
        check("async_pc", PC, 32'd0);
        check("async_valid", {31'd0, instr_valid}, 32'd0);
        check("async_halted", {31'd0, halted}, 32'd0);
`ifdef PC_CONTROL_RETIRE_CNT_EN
        check("async_retired", retired_count, 32'd0);
`endif
        @(negedge clk);
        reset = 1'b0;
        cycle(1'b0, 1'b0, 32'd0, 1'b0, "after_async");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_control.md
Name: pc_control

Overview:
- Program-counter and fetch-sequencing stage, directly upstream of instruction fetch.
- Owns the architectural PC register and presents it to the instruction ROM.
- The ROM has synchronous read and 1-cycle latency, so this block sequences each instruction as FETCH then EXEC, and tells the datapath when the ROM output is valid.
- Selects the next PC from sequential increment or a resolved branch target; supports stall, halt and out-of-range fault.

Parameters:
RESET_PC, 32'd0, PC value loaded on reset
PC_STEP, 32'd1, sequential increment (PC is a word address into instruction ROM)
IMEM_DEPTH, 1024, number of valid instruction words; PC >= IMEM_DEPTH is out of range

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
stall  input  1  datapath not ready; hold current instruction in EXEC
branch_taken  input  1  resolved branch/jump this EXEC cycle
branch_target  input  32  absolute next PC when branch_taken=1
halt_req  input  1  halt instruction decoded this EXEC cycle
PC  output  32  current PC, drives fetch stage address
PC_next_seq  output  32  PC + PC_STEP (combinational, for link register writes)
instr_valid  output  1  fetch-stage instruction output valid this cycle
halted  output  1  core halted (sticky until reset)
pc_fault  output  1  halt caused by out-of-range next PC (sticky until reset)

Behaviour:
- Reset: asynchronous, active-high. Applies immediately, including mid-instruction.
  - PC=RESET_PC, state=FETCH, instr_valid=0, halted=0, pc_fault=0.
  - First FETCH begins on the first rising edge after deassert.
- States: FETCH, EXEC, HALT. The encoding is free but must be one register.
- FETCH:
  - instr_valid=0; PC stable, presented to ROM.
  - Next edge: go to EXEC unconditionally.
- EXEC:
  - instr_valid=1; ROM output reflects the current PC.
  - Priority on the edge: halt_req > stall > PC update.
  - halt_req=1: go to HALT; PC held; halted=1 from the next cycle.
  - else stall=1: stay in EXEC; PC held; instr_valid stays 1.
  - else: next = branch_taken ? branch_target : PC+PC_STEP.
    - If next >= IMEM_DEPTH: go to HALT; PC held at the faulting instruction; halted=1 and pc_fault=1 next cycle.
    - Otherwise PC<=next; go to FETCH.
- HALT:
  - instr_valid=0; PC frozen; all inputs ignored.
  - Exit only via reset.
- Throughput: 2 cycles per instruction with no stall; each stall cycle adds exactly 1 cycle.
- Arithmetic:
  - 32-bit unsigned; PC+PC_STEP wraps modulo 2^32 before the range check (a wrapped value < IMEM_DEPTH is legal).
  - branch_target is used as-is (no alignment or masking).
- branch_taken, branch_target, stall and halt_req are sampled only in EXEC; they are don't-care in FETCH and HALT.
- PC_next_seq is always PC+PC_STEP, in every state.

Optional Feature:
Macro: PC_CONTROL_RETIRE_CNT_EN
- Defined:
  - Adds output port retired_count [31:0].
  - Reset value 0.
  - Increments by 1 on each edge where EXEC commits a PC update (the transition to FETCH).
  - Does not count stall cycles, halt, or fault exits.
  - Wraps modulo 2^32.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset then free-run, no branches, stall=0 → PC sequence 0,0,1,1,2,2… (one value per FETCH/EXEC pair); instr_valid toggles 0,1,0,1.
- In EXEC at PC=5 assert branch_taken=1, branch_target=40 → next FETCH has PC=40; PC_next_seq=6 during the EXEC at PC=5.
- At PC=3 in EXEC hold stall=1 for 3 cycles, with branch_taken=1 concurrently → PC stays 3 and instr_valid=1 for 4 EXEC cycles total; then branch taken on the first non-stall edge.
- At PC=1023 (IMEM_DEPTH=1024), no branch → HALT with PC=1023, halted=1, pc_fault=1, instr_valid=0; still frozen 10 cycles later. Separately, branch_target=2000 → same fault behaviour.
- halt_req=1 together with stall=1 and branch_taken=1 at PC=7 → HALT, PC=7, halted=1, pc_fault=0.
- Assert reset asynchronously between clock edges during EXEC at PC=12 → PC=0, instr_valid=0, halted=0 before the next edge; with PC_CONTROL_RETIRE_CNT_EN defined, retired_count=0 after reset and equals 12 just before the reset was applied.
